// File: rtl/mul_ctrl.sv
// Sequential shift-add multiplier controller for the RV32M MUL/MULH/MULHSU/MULHU group.
// All arithmetic goes through a shared external ALU. Optional macro: MUL_CTRL_ZERO_BYPASS_EN.
module mul_ctrl #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_op,
   input  logic [N-1:0] req_a,
   input  logic [N-1:0] req_b,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [N-1:0] resp_data,
   output logic         busy,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_sel,
   input  logic [N-1:0] alu_res
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // the producer holds its payload until then, and the consumer never takes it otherwise.

   typedef enum logic [2:0] {IDLE, PREP_A, PREP_B, ITER, NEG_LO, NEG_HI, DONE} state_t;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b1100;
   localparam int         CW        = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_t          state, state_nx;
   logic [N-1:0]    mcand, hi, lo;
   logic [CW-1:0]   cnt;
   logic [1:0]      op_q;
   logic            sign_a, sign_b;
   logic            accept, zero_bypass, neg, carry, iter_last, low_result;

   assign req_ready  = (state == IDLE) && rst_n;
   assign accept     = req_valid && req_ready;
   assign busy       = (state != IDLE);
   assign resp_valid = (state == DONE);
   assign neg        = sign_a ^ sign_b;
   assign iter_last  = (cnt == CNT_LAST);
   assign low_result = (op_q == OP_MUL) || (op_q == OP_MULHU);
   assign carry      = (hi[N-1] & alu_b[N-1]) | ((hi[N-1] | alu_b[N-1]) & ~alu_res[N-1]);

`ifdef MUL_CTRL_ZERO_BYPASS_EN
   assign zero_bypass = (req_a == '0) || (req_b == '0);
`else
   assign zero_bypass = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (zero_bypass)                                     state_nx = DONE;
               else if (req_op == OP_MUL || req_op == OP_MULHU)     state_nx = ITER;
               else                                                 state_nx = PREP_A;
            end
         end
         PREP_A:  state_nx = (op_q == OP_MULH) ? PREP_B : ITER;
         PREP_B:  state_nx = ITER;
         ITER:    if (iter_last) state_nx = low_result ? DONE : NEG_LO;
         NEG_LO:  state_nx = NEG_HI;
         NEG_HI:  state_nx = DONE;
         DONE:    if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_sel = ALU_ADD;
      case (state)
         PREP_A: begin alu_b = mcand; alu_sel = ALU_SUB; end
         PREP_B: begin alu_b = lo;    alu_sel = ALU_SUB; end
         ITER: begin
            alu_a = hi;
            alu_b = lo[0] ? mcand : '0;
         end
         NEG_LO: begin alu_b = lo; alu_sel = ALU_SUB; end
         // -lo is zero exactly when the original lo was zero, so the carry into hi is still correct.
         NEG_HI: begin alu_a = ~hi; alu_b = {{(N-1){1'b0}}, (lo == '0)}; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand     <= '0;
         hi        <= '0;
         lo        <= '0;
         cnt       <= '0;
         op_q      <= OP_MUL;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         resp_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand  <= req_a;
                  lo     <= req_b;
                  hi     <= '0;
                  cnt    <= '0;
                  op_q   <= req_op;
                  sign_a <= req_a[N-1] & ((req_op == OP_MULH) || (req_op == OP_MULHSU));
                  sign_b <= req_b[N-1] & (req_op == OP_MULH);
                  if (zero_bypass) resp_data <= '0;
               end
            end
            PREP_A: if (mcand[N-1]) mcand <= alu_res;
            PREP_B: if (lo[N-1])    lo    <= alu_res;
            ITER: begin
               {hi, lo} <= {carry, alu_res, lo[N-1:1]};
               cnt      <= iter_last ? '0 : cnt + 1'b1;
               if (iter_last && low_result)
                  resp_data <= (op_q == OP_MUL) ? {alu_res[0], lo[N-1:1]} : {carry, alu_res[N-1:1]};
            end
            NEG_LO: if (neg) lo <= alu_res;
            NEG_HI: begin
               if (neg) hi <= alu_res;
               resp_data <= neg ? alu_res : hi;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: directed corner products, response hold, mid-run reset,
// then randomized operations checked against a wide-integer reference model.
module tb_mul_ctrl;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_op;
   logic [N-1:0] req_a, req_b;
   logic         resp_valid;
   logic         resp_ready;
   logic [N-1:0] resp_data;
   logic         busy;
   logic [N-1:0] alu_a, alu_b, alu_res;
   logic [3:0]   alu_sel;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Shared ALU stand-in: 1100 subtracts, everything else adds.
   assign alu_res = (alu_sel == 4'b1100) ? alu_a - alu_b : alu_a + alu_b;

   mul_ctrl #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_res    (alu_res)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: extend each operand to 2N+2 bits by the op's signedness and multiply.
   function automatic logic [N-1:0] ref_result(input logic [1:0] op, input logic [N-1:0] a,
                                                input logic [N-1:0] b);
      logic signed [2*N+1:0] ea, eb, p;
      logic sa, sb;
      sa = (op == 2'b01) || (op == 2'b10);
      sb = (op == 2'b01);
      ea = {{(N+2){sa & a[N-1]}}, a};
      eb = {{(N+2){sb & b[N-1]}}, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[N-1:0] : p[2*N-1:N];
   endfunction

   function automatic int ref_latency(input logic [1:0] op, input logic [N-1:0] a,
                                      input logic [N-1:0] b);
`ifdef MUL_CTRL_ZERO_BYPASS_EN
      if (a == '0 || b == '0) return 1;
`endif
      case (op)
         2'b01:   return N + 5;
         2'b10:   return N + 4;
         default: return N + 1;
      endcase
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int hold, input string tag);
      logic [N-1:0] exp;
      int exp_lat, lat;
      exp     = ref_result(op, a, b);
      exp_lat = ref_latency(op, a, b);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      #1 check({tag, " req_ready"}, 64'(req_ready), 64'(1));
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 2'($urandom_range(3, 0));
      req_a     = N'($urandom);
      req_b     = N'($urandom);
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " data"}, 64'(resp_data), 64'(exp));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, " hold valid"}, 64'(resp_valid), 64'(1));
         check({tag, " hold data"}, 64'(resp_data), 64'(exp));
         check({tag, " hold req_ready"}, 64'(req_ready), 64'(0));
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check({tag, " post valid"}, 64'(resp_valid), 64'(0));
      check({tag, " post busy"}, 64'(busy), 64'(0));
      check({tag, " post req_ready"}, 64'(req_ready), 64'(1));
   endtask

   function automatic logic [N-1:0] pick_operand(input int mode);
      case (mode)
         0:       return '0;
         1:       return N'(1);
         2:       return {1'b1, {(N-1){1'b0}}};
         3:       return '1;
         default: return N'($urandom);
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst req_ready", 64'(req_ready), 64'(0));
      check("rst busy", 64'(busy), 64'(0));
      check("rst resp_valid", 64'(resp_valid), 64'(0));
      check("rst resp_data", 64'(resp_data), 64'(0));
      check("rst alu_sel", 64'(alu_sel), 64'(0));
      check("rst alu_a", 64'(alu_a), 64'(0));
      rst_n = 1'b1;
      #1 check("rst release req_ready", 64'(req_ready), 64'(1));

      run_op(2'b00, 32'd7, 32'd6, 5, "mul 7x6");
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh -1x-1");
      run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu max");
      run_op(2'b10, 32'h8000_0000, 32'h0000_0002, 1, "mulhsu min x2");
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, "mulh min x min");
      run_op(2'b01, 32'h0000_0000, 32'h1234_5678, 2, "mulh zero");
      run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu -1 x max");

      // Reset in the middle of an iteration run discards the operation.
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'h0000_1234; req_b = 32'h0000_5678;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("mid busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst busy", 64'(busy), 64'(0));
      check("midrst resp_valid", 64'(resp_valid), 64'(0));
      check("midrst req_ready", 64'(req_ready), 64'(0));
      check("midrst resp_data", 64'(resp_data), 64'(0));
      rst_n = 1'b1;
      #1 check("midrst release req_ready", 64'(req_ready), 64'(1));
      run_op(2'b00, 32'd3, 32'd5, 0, "mul 3x5 after reset");

      for (int k = 0; k < 40; k++) begin
         logic [1:0]   op;
         logic [N-1:0] a, b;
         op = 2'($urandom_range(3, 0));
         a  = pick_operand(int'($urandom_range(0, 9)));
         b  = pick_operand(int'($urandom_range(0, 9)));
         run_op(op, a, b, int'($urandom_range(0, 2)), $sformatf("rand%0d op%0d", k, op));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have parameter: N, 32, operand/result width (N >= 4).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req_valid  in  1  request present.
REQ-005 SHALL have port: req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-006 SHALL have port: req_op  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 SHALL have port: req_a  in  N  multiplicand (rs1).
REQ-008 SHALL have port: req_b  in  N  multiplier (rs2).
REQ-009 SHALL have port: resp_valid  out  1  result present.
REQ-010 SHALL have port: resp_ready  in  1  consumer takes result.
REQ-011 SHALL have port: resp_data  out  N  result.
REQ-012 SHALL have port: busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have ports alu_a out N, alu_b out N, alu_sel out 4, alu_res in N, connected to the shared ALU: add 0000, sub 1100.

Function
REQ-014 SHALL implement the FSM states IDLE, PREP_A, PREP_B, ITER, NEG_LO, NEG_HI, DONE; each non-ITER state lasts exactly one cycle; DONE persists until resp_ready is high.
REQ-015 SHALL drive req_ready = (state==IDLE) and rst_n; acceptance = req_valid and req_ready; on acceptance, capture operands, op and sign flags.
REQ-016 SHALL use these sequences after acceptance. MUL and MULHU: ITER, DONE. MULH: PREP_A, PREP_B, ITER, NEG_LO, NEG_HI, DONE. MULHSU: PREP_A, ITER, NEG_LO, NEG_HI, DONE.
REQ-017 SHALL give resp_valid latency after the acceptance edge of N+1 cycles for MUL/MULHU, N+5 for MULH, and N+4 for MULHSU.
REQ-018 PREP_A/PREP_B SHALL replace the captured operand with its magnitude: alu_a=0, alu_b=operand, alu_sel=sub, result used only if the operand MSB=1; 0x80000000 stays 0x80000000.
REQ-019 ITER SHALL run exactly N cycles with a counter 0..N-1. Per cycle:
  - alu_a=hi, alu_b=(lo[0] ? mcand : 0), alu_sel=add;
  - carry = (hi[N-1]&b[N-1]) | ((hi[N-1]|b[N-1]) & ~alu_res[N-1]);
  - {hi,lo} <= {carry, alu_res, lo[N-1:1]}; hi is 0 at ITER start and lo holds the multiplier.
REQ-020 NEG_LO/NEG_HI SHALL negate {hi,lo} when result sign = sign_a XOR sign_b. sign_b is forced to 0 for MULHSU; both signs are 0 for unsigned ops.
  - NEG_LO: alu_a=0, alu_b=lo, sub.
  - NEG_HI: alu_a=~hi, alu_b=(original lo==0), add.
  - With sign 0, hi and lo SHALL be left unchanged.
REQ-021 resp_data SHALL be lo for MUL and hi otherwise; it is registered on entry to DONE and held stable while resp_valid=1 and resp_ready=0.
REQ-022 DONE with resp_ready=1 SHALL go to IDLE on the next edge; a new request SHALL NOT be accepted in the same cycle as the response handoff.
REQ-023 In IDLE and DONE, SHALL drive alu_a=0, alu_b=0, alu_sel=add.
REQ-024 req_a/req_b/req_op changes after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-025 When rst_n=0 at a rising edge, in any state including mid-ITER, SHALL enter IDLE and discard in-flight work.
REQ-026 Reset values SHALL be: resp_valid=0, resp_data=0, busy=0, counter=0, hi=lo=0; req_ready=0 while rst_n=0.

Configuration
REQ-027 With MUL_CTRL_ZERO_BYPASS_EN defined, an accepted request with req_a==0 or req_b==0 SHALL go IDLE->DONE directly, with resp_data=0 and resp_valid one cycle after acceptance.
REQ-028 Without MUL_CTRL_ZERO_BYPASS_EN, zero operands SHALL follow REQ-016 latency unchanged.

Verification
REQ-029 SHALL cover: MUL 7 x 6 -> resp_valid at cycle 33 after acceptance, resp_data=0x0000002A.
REQ-030 SHALL cover: MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000 at cycle 37; MULHU same operands -> 0xFFFFFFFE at cycle 33.
REQ-031 SHALL cover: MULHSU 0x80000000 x 0x00000002 -> 0xFFFFFFFF at cycle 36; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-032 SHALL cover: resp_ready held low 5 cycles in DONE -> resp_valid=1, resp_data stable, req_ready=0; resp_ready=1 -> IDLE next cycle, req_ready=1.
REQ-033 SHALL cover: rst_n=0 during ITER cycle 10 -> next cycle busy=0, resp_valid=0; after release req_ready=1 and the next MUL 3 x 5 returns 15.
REQ-034 SHALL cover, with MUL_CTRL_ZERO_BYPASS_EN: MULH 0 x 0x12345678 -> resp_valid 1 cycle after acceptance, resp_data=0.
